data_cache_controller: RTL and testbench

DATA_CACHE_CONTROLLER -- requirements
Module: data_cache_controller

---
 rtl/dcache_pkg.sv | 20 ++
 rtl/dcache_line_store.sv | 59 +++++
 rtl/data_cache_controller.sv | 164 ++++++++++++++++
 tb/tb_data_cache_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped, write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } dcache_state_e;

  localparam int unsigned LINE_BYTES    = 16;
  localparam int unsigned OFFSET_W      = 2;   // word offset within a line
  localparam int unsigned DEFAULT_LINES = 16;

  // Pick one 32-bit word out of a line; byte k of the line sits at [8k+7:8k].
  function automatic logic [31:0] select_word(input logic [LINE_BYTES*8-1:0] line,
                                              input logic [OFFSET_W-1:0]     off);
    return line[32*off +: 32];
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/tag/data arrays for the data cache: one combinational read port,
// one full-line fill port and one word-write port.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int unsigned LINES   = DEFAULT_LINES,
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned TAG_W   = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // Read port
  input  logic [INDEX_W-1:0]        rd_index,
  output logic                      rd_valid,
  output logic [TAG_W-1:0]          rd_tag,
  output logic [LINE_BYTES*8-1:0]   rd_line,
  // Line fill
  input  logic                      fill_en,
  input  logic [INDEX_W-1:0]        fill_index,
  input  logic [TAG_W-1:0]          fill_tag,
  input  logic [LINE_BYTES*8-1:0]   fill_data,
  // Word write
  input  logic                      wr_en,
  input  logic [INDEX_W-1:0]        wr_index,
  input  logic [OFFSET_W-1:0]       wr_offset,
  input  logic [31:0]               wr_data
);

  logic [LINES-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_q  [LINES];
  logic [LINE_BYTES*8-1:0] data_q [LINES];

  // Asynchronous array read.
  always_comb begin
    rd_valid = valid_q[rd_index];
    rd_tag   = tag_q[rd_index];
    rd_line  = data_q[rd_index];
  end

  // Valid bits are the only state cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_index] <= 1'b1;
    end
  end

  // Tag and data arrays; fill and word write never coincide.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= fill_data;
    end else if (wr_en) begin
      data_q[wr_index][32*wr_offset +: 32] <= wr_data;
    end
  end

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Read hits complete with zero latency; misses fetch a 128-bit line.
// Optional feature: define DCACHE_STATS_EN to add hitCount/missCount ports.
module data_cache_controller #(
  parameter int unsigned LINES      = dcache_pkg::DEFAULT_LINES,
  parameter int unsigned LINE_BYTES = dcache_pkg::LINE_BYTES
) (
  input  logic                    CLk,
  input  logic                    resetN,
  input  logic [31:0]             cpuAddress,
  input  logic                    cpuRead,
  input  logic                    cpuWrite,
  input  logic [31:0]             cpuWriteData,
  output logic [31:0]             cpuReadData,
  output logic                    stall,
  output logic                    memReq,
  output logic [31:0]             memAddress,
  output logic                    memWrite,
  output logic [31:0]             memWriteData,
  input  logic [LINE_BYTES*8-1:0] memData,
  input  logic                    memValid
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]             hitCount,
  output logic [31:0]             missCount
`endif
);

  import dcache_pkg::*;

  localparam int unsigned INDEX_W = $clog2(LINES);
  localparam int unsigned TAG_W   = 32 - 4 - INDEX_W;

  dcache_state_e state_q, state_d;
  logic [31:2]   addr_q, addr_d;     // request address latched when leaving IDLE
  logic [31:0]   wdata_q, wdata_d;

  logic [31:2]             lookup_addr;
  logic                    rd_valid;
  logic [TAG_W-1:0]        rd_tag;
  logic [LINE_BYTES*8-1:0] rd_line;
  logic                    hit;
  logic [31:0]             rd_word;
  logic                    fill_en;
  logic                    wr_en;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^cpuAddress[1:0];

  // IDLE looks up the live CPU address; WRITE checks the latched one for a hit.
  always_comb begin
    lookup_addr = (state_q == IDLE) ? cpuAddress[31:2] : addr_q;
    hit         = rd_valid && (rd_tag == lookup_addr[31 -: TAG_W]);
    rd_word     = select_word(rd_line, lookup_addr[3:2]);
  end

  dcache_line_store #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_line_store (
    .clk        (CLk),
    .rst_n      (resetN),
    .rd_index   (lookup_addr[4 +: INDEX_W]),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_line    (rd_line),
    .fill_en    (fill_en),
    .fill_index (addr_q[4 +: INDEX_W]),
    .fill_tag   (addr_q[31 -: TAG_W]),
    .fill_data  (memData),
    .wr_en      (wr_en),
    .wr_index   (addr_q[4 +: INDEX_W]),
    .wr_offset  (addr_q[3:2]),
    .wr_data    (wdata_q)
  );

  // Next-state and outputs; everything is held at zero while resetN is low.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    stall        = 1'b0;
    memReq       = 1'b0;
    memWrite     = 1'b0;
    memAddress   = '0;
    memWriteData = '0;
    cpuReadData  = '0;
    fill_en      = 1'b0;
    wr_en        = 1'b0;
    if (resetN) begin
      unique case (state_q)
        IDLE: begin
          if (cpuWrite) begin
            stall   = 1'b1;
            addr_d  = cpuAddress[31:2];
            wdata_d = cpuWriteData;
            state_d = WRITE;
          end else if (cpuRead) begin
            if (hit) begin
              cpuReadData = rd_word;
            end else begin
              stall   = 1'b1;
              addr_d  = cpuAddress[31:2];
              state_d = FETCH;
            end
          end
        end
        FETCH: begin
          stall      = 1'b1;
          memReq     = 1'b1;
          memAddress = {addr_q[31:4], 4'b0};
          if (memValid) begin
            fill_en = 1'b1;
            state_d = IDLE;
          end
        end
        WRITE: begin
          memWrite     = 1'b1;
          memAddress   = {addr_q, 2'b0};
          memWriteData = wdata_q;
          wr_en        = hit;   // write miss leaves the cache untouched
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and latched request registers.
  always_ff @(posedge CLk) begin
    if (!resetN) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;
  logic        read_lookup;

  assign read_lookup = resetN && (state_q == IDLE) && cpuRead && !cpuWrite;

  // Read hit/miss counters; wrap naturally at 2^32.
  always_ff @(posedge CLk) begin
    if (!resetN) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (read_lookup) begin
      if (hit) hit_count_q  <= hit_count_q + 32'd1;
      else     miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hitCount  = hit_count_q;
  assign missCount = miss_count_q;
`endif

endmodule

// File: tb/tb_data_cache_controller.sv
// Directed self-checking bench for data_cache_controller (LINES=16).
module tb_data_cache_controller;

  logic         CLk = 1'b0;
  logic         resetN = 1'b0;
  logic [31:0]  cpuAddress = '0;
  logic         cpuRead = 1'b0;
  logic         cpuWrite = 1'b0;
  logic [31:0]  cpuWriteData = '0;
  logic [31:0]  cpuReadData;
  logic         stall;
  logic         memReq;
  logic [31:0]  memAddress;
  logic         memWrite;
  logic [31:0]  memWriteData;
  logic [127:0] memData = '0;
  logic         memValid = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hitCount;
  logic [31:0]  missCount;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLk = ~CLk;

  data_cache_controller #(.LINES(16)) dut (
    .CLk          (CLk),
    .resetN       (resetN),
    .cpuAddress   (cpuAddress),
    .cpuRead      (cpuRead),
    .cpuWrite     (cpuWrite),
    .cpuWriteData (cpuWriteData),
    .cpuReadData  (cpuReadData),
    .stall        (stall),
    .memReq       (memReq),
    .memAddress   (memAddress),
    .memWrite     (memWrite),
    .memWriteData (memWriteData),
    .memData      (memData),
    .memValid     (memValid)
`ifdef DCACHE_STATS_EN
    ,
    .hitCount     (hitCount),
    .missCount    (missCount)
`endif
  );

  // Memory line image: byte k = (addr[7:0] + k) ^ addr[15:8].
  function automatic logic [127:0] line_for(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = (a[7:0] + 8'(k)) ^ a[15:8];
    return l;
  endfunction

  task automatic step();
    @(posedge CLk);
    #2;
  endtask

  task automatic test_reset();
    resetN = 1'b0; cpuRead = 1'b1; cpuWrite = 1'b1;
    cpuAddress = 32'h24; cpuWriteData = 32'h1234_5678;
    step(); step(); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%h want=0", stall); end
    checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL rst_memReq got=%h want=0", memReq); end
    checks++; if (memWrite !== 1'b0) begin failures++; $display("FAIL rst_memWrite got=%h want=0", memWrite); end
    checks++; if (memAddress !== 32'h0) begin failures++; $display("FAIL rst_memAddress got=%h want=0", memAddress); end
    checks++; if (memWriteData !== 32'h0) begin failures++; $display("FAIL rst_memWriteData got=%h want=0", memWriteData); end
    checks++; if (cpuReadData !== 32'h0) begin failures++; $display("FAIL rst_cpuReadData got=%h want=0", cpuReadData); end
    resetN = 1'b1; cpuRead = 1'b0; cpuWrite = 1'b0; cpuWriteData = '0;
    #1;
    checks++; if (stall !== 1'b0 || memReq !== 1'b0 || memWrite !== 1'b0) begin
      failures++; $display("FAIL idle_outputs got stall=%h memReq=%h memWrite=%h want 0/0/0", stall, memReq, memWrite);
    end
  endtask

  task automatic test_cold_miss();
    step();
    cpuRead = 1'b1; cpuAddress = 32'h24; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL cold_stall_idle got=%h want=1", stall); end
    checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL cold_memReq_idle got=%h want=0", memReq); end
    step(); #1;
    checks++; if (memReq !== 1'b1 || stall !== 1'b1) begin
      failures++; $display("FAIL cold_fetch got memReq=%h stall=%h want 1/1", memReq, stall);
    end
    checks++; if (memAddress !== 32'h20) begin failures++; $display("FAIL cold_memAddress got=%h want=00000020", memAddress); end
    step(); step(); #1;
    checks++; if (memReq !== 1'b1 || memAddress !== 32'h20) begin
      failures++; $display("FAIL cold_wait got memReq=%h memAddress=%h want 1/00000020", memReq, memAddress);
    end
    memData = line_for(32'h20); memValid = 1'b1;
    step();
    memValid = 1'b0; memData = '0; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL cold_retry_stall got=%h want=0", stall); end
    checks++; if (cpuReadData !== 32'h2726_2524) begin failures++; $display("FAIL cold_retry_data got=%h want=27262524", cpuReadData); end
    checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL cold_retry_memReq got=%h want=0", memReq); end
  endtask

  task automatic test_hit_after_fill();
    step();
    cpuAddress = 32'h28; #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL hit_stall got=%h want=0", stall); end
    checks++; if (cpuReadData !== 32'h2B2A_2928) begin failures++; $display("FAIL hit_data got=%h want=2b2a2928", cpuReadData); end
    checks++; if (memReq !== 1'b0) begin failures++; $display("FAIL hit_memReq got=%h want=0", memReq); end
  endtask

  task automatic test_write_hit();
    step();
    cpuRead = 1'b0; cpuWrite = 1'b1; cpuAddress = 32'h24; cpuWriteData = 32'hDEAD_BEEF; #1;
    checks++; if (stall !== 1'b1 || memWrite !== 1'b0) begin
      failures++; $display("FAIL wr_idle got stall=%h memWrite=%h want 1/0", stall, memWrite);
    end
    step();
    cpuWrite = 1'b0; cpuWriteData = '0; #1;
    checks++; if (memWrite !== 1'b1 || stall !== 1'b0) begin
      failures++; $display("FAIL wr_cycle got memWrite=%h stall=%h want 1/0", memWrite, stall);
    end
    checks++; if (memAddress !== 32'h24) begin failures++; $display("FAIL wr_memAddress got=%h want=00000024", memAddress); end
    checks++; if (memWriteData !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_memWriteData got=%h want=deadbeef", memWriteData); end
    step();
    cpuRead = 1'b1; cpuAddress = 32'h24; #1;
    checks++; if (memWrite !== 1'b0) begin failures++; $display("FAIL wr_one_cycle got=%h want=0", memWrite); end
    checks++; if (stall !== 1'b0 || memReq !== 1'b0) begin
      failures++; $display("FAIL wr_readback_hit got stall=%h memReq=%h want 0/0", stall, memReq);
    end
    checks++; if (cpuReadData !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_readback got=%h want=deadbeef", cpuReadData); end
  endtask

  // Read+write together: write wins; a write miss must not allocate or corrupt.
  task automatic test_write_priority_miss();
    step();
    cpuRead = 1'b1; cpuWrite = 1'b1; cpuAddress = 32'h124; cpuWriteData = 32'hCAFE_F00D; #1;
    checks++; if (stall !== 1'b1 || memReq !== 1'b0) begin
      failures++; $display("FAIL prio_idle got stall=%h memReq=%h want 1/0", stall, memReq);
    end
    step();
    cpuRead = 1'b0; cpuWrite = 1'b0; #1;
    checks++; if (memWrite !== 1'b1 || memReq !== 1'b0 || memAddress !== 32'h124) begin
      failures++; $display("FAIL prio_write got memWrite=%h memReq=%h memAddress=%h want 1/0/00000124", memWrite, memReq, memAddress);
    end
    checks++; if (memWriteData !== 32'hCAFE_F00D) begin failures++; $display("FAIL prio_wdata got=%h want=cafef00d", memWriteData); end
    step();
    cpuRead = 1'b1; cpuAddress = 32'h24; #1;
    checks++; if (stall !== 1'b0 || cpuReadData !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL wmiss_no_alloc got stall=%h data=%h want 0/deadbeef", stall, cpuReadData);
    end
  endtask

  task automatic test_conflict();
    step();
    cpuAddress = 32'h124; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL conf_miss got=%h want=1", stall); end
    step(); #1;
    checks++; if (memReq !== 1'b1 || memAddress !== 32'h120) begin
      failures++; $display("FAIL conf_fetch got memReq=%h memAddress=%h want 1/00000120", memReq, memAddress);
    end
    memData = line_for(32'h120); memValid = 1'b1;
    step();
    memValid = 1'b0; #1;
    checks++; if (stall !== 1'b0 || cpuReadData !== 32'h2627_2425) begin
      failures++; $display("FAIL conf_data got stall=%h data=%h want 0/26272425", stall, cpuReadData);
    end
    step();
    cpuAddress = 32'h24; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL conf_evicted got=%h want=1", stall); end
    step(); #1;
    checks++; if (memReq !== 1'b1 || memAddress !== 32'h20) begin
      failures++; $display("FAIL conf_refetch got memReq=%h memAddress=%h want 1/00000020", memReq, memAddress);
    end
    memData = line_for(32'h20); memValid = 1'b1;
    step();
    memValid = 1'b0; #1;
    checks++; if (stall !== 1'b0 || cpuReadData !== 32'h2726_2524) begin
      failures++; $display("FAIL conf_refill got stall=%h data=%h want 0/27262524", stall, cpuReadData);
    end
  endtask

  task automatic test_reset_mid_fetch();
    step();
    cpuAddress = 32'h44; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rmf_miss got=%h want=1", stall); end
    step(); #1;
    checks++; if (memReq !== 1'b1 || memAddress !== 32'h40) begin
      failures++; $display("FAIL rmf_fetch got memReq=%h memAddress=%h want 1/00000040", memReq, memAddress);
    end
    resetN = 1'b0; #1;
    checks++; if (memReq !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL rmf_in_reset got memReq=%h stall=%h want 0/0", memReq, stall);
    end
    step();
    resetN = 1'b1; cpuRead = 1'b0; memData = line_for(32'h40); memValid = 1'b1; #1;
    checks++; if (memReq !== 1'b0 || stall !== 1'b0) begin
      failures++; $display("FAIL rmf_dropped got memReq=%h stall=%h want 0/0", memReq, stall);
    end
    step();
    memValid = 1'b0; memData = '0; cpuRead = 1'b1; cpuAddress = 32'h44; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rmf_late_ignored got=%h want=1", stall); end
    cpuAddress = 32'h24; #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL rmf_valid_cleared got=%h want=1", stall); end
    resetN = 1'b0; cpuRead = 1'b0;
    step();
    resetN = 1'b1;
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    resetN = 1'b0; cpuRead = 1'b0; cpuWrite = 1'b0;
    step();
    resetN = 1'b1; #1;
    checks++; if (hitCount !== 32'd0 || missCount !== 32'd0) begin
      failures++; $display("FAIL stats_reset got hit=%0d miss=%0d want 0/0", hitCount, missCount);
    end
    cpuRead = 1'b1; cpuAddress = 32'h24;
    step();
    memData = line_for(32'h20); memValid = 1'b1;
    step();
    memValid = 1'b0;
    step();
    cpuAddress = 32'h28;
    step();
    cpuRead = 1'b0; #1;
    checks++; if (hitCount !== 32'd2 || missCount !== 32'd1) begin
      failures++; $display("FAIL stats_counts got hit=%0d miss=%0d want 2/1", hitCount, missCount);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_after_fill();
    test_write_hit();
    test_write_priority_miss();
    test_conflict();
    test_reset_mid_fetch();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
